// File: rtl/gray_pkg.sv
// Shared constants, collector state encoding and the luma helper for rgb_grayscaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gray_pkg;

  // Width of the weighted sum. The largest value is 255*256 + 128 = 65408,
  // so 16 bits never overflow.
  localparam int SUM_W = 16;

  // BT.601-style luma weights scaled by 256. They add up to 256, so full white maps to 255.
  localparam logic [SUM_W-1:0] W_R   = 16'd77;
  localparam logic [SUM_W-1:0] W_G   = 16'd150;
  localparam logic [SUM_W-1:0] W_B   = 16'd29;
  localparam logic [SUM_W-1:0] ROUND = 16'd128;

  // Position of the next expected byte within an interleaved R,G,B triple.
  typedef enum logic [1:0] {
    GET_R = 2'b00,
    GET_G = 2'b01,
    GET_B = 2'b10
  } coll_state_t;

  // Rounded luma: (77*r + 150*g + 29*b + 128) >> 8.
  function automatic logic [7:0] luma(input logic [7:0] r,
                                      input logic [7:0] g,
                                      input logic [7:0] b);
    logic [SUM_W-1:0] sum;
    sum = W_R * {8'd0, r} + W_G * {8'd0, g} + W_B * {8'd0, b} + ROUND;
    return 8'(sum >> 8);
  endfunction

endpackage

// File: rtl/gray_out_fifo.sv
// First-word fall-through FIFO with an occupancy count, used to buffer gray pixels.
// Latency: a word pushed at an edge is visible on head right after that edge.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   clear         synchronous flush; empties the FIFO at the next edge
//   push/push_data  write request and data
//   pop           remove the head (only asserted while not_empty)
//   head          head word; forced to 0 while empty
//   not_empty     FIFO holds at least one word
//   full          FIFO holds DEPTH words
//   count         current occupancy, 0..DEPTH
module gray_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;

  // With a simultaneous pop, the slot being freed makes room even when full.
  assign wr_ok     = push && (!full || pop);
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head      = not_empty ? mem[rd_ptr] : '0;

  // Wrap explicitly so depths that are not a power of two also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_grayscaler.sv
// Collects interleaved R,G,B bytes into pixels, converts each pixel to 8-bit luma and buffers the results.
// Latency: out_valid rises two edges after the B byte is accepted, when the FIFO was empty.
// Backpressure: input is never stalled; pause throttles the source early enough that the FIFO cannot overflow.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   clear                synchronous flush of the partial pixel, FIFO, counters and overflow flag
//   in_data, in_valid    byte stream; each valid cycle is consumed, data ignored otherwise
//   pause                asks the source to stop sending bytes
//   out_data, out_valid  FIFO head and not-empty flag
//   out_ready            downstream pops the head when out_valid & out_ready
//   frame_done           one-cycle pulse on the pop of the last pixel of a frame
//   overflow             sticky: a finished pixel found the FIFO full and was dropped
module rgb_grayscaler
  import gray_pkg::*;
#(
  parameter int N         = 2,
  parameter int M         = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       pause,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       overflow
);

  localparam int FRAME_PIX = N * M;
  localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIX - 1);
  localparam logic [CNT_W:0]   PAUSE_TH = (CNT_W + 1)'(OUT_DEPTH - 1);

  // ---------------------------------------------------------------
  // Collector FSM
  // ---------------------------------------------------------------
  coll_state_t state_q;
  coll_state_t state_d;
  logic        cap_r;
  logic        cap_g;
  logic        cap_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_R;
    end else if (clear) begin
      state_q <= GET_R;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_r   = 1'b0;
    cap_g   = 1'b0;
    cap_b   = 1'b0;
    if (in_valid) begin
      case (state_q)
        GET_R: begin
          cap_r   = 1'b1;
          state_d = GET_G;
        end
        GET_G: begin
          cap_g   = 1'b1;
          state_d = GET_B;
        end
        GET_B: begin
          cap_b   = 1'b1;
          state_d = GET_R;
        end
        default: begin
          state_d = GET_R;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Byte registers and compute pipeline
  // ---------------------------------------------------------------
  logic [7:0] r_reg;
  logic [7:0] g_reg;
  logic [7:0] b_reg;
  logic       pix_ready;     // all three bytes of a pixel are held
  logic       compute_busy;  // gray_reg holds a pixel to push this cycle
  logic [7:0] gray_reg;

  // FIFO interface
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;

  // Frame counters
  logic [PIX_W-1:0] pix_in_cnt;
  logic [PIX_W-1:0] pix_out_cnt;

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg        <= '0;
      g_reg        <= '0;
      b_reg        <= '0;
      pix_ready    <= 1'b0;
      compute_busy <= 1'b0;
      gray_reg     <= '0;
      pix_in_cnt   <= '0;
      pix_out_cnt  <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      r_reg        <= '0;
      g_reg        <= '0;
      b_reg        <= '0;
      pix_ready    <= 1'b0;
      compute_busy <= 1'b0;
      gray_reg     <= '0;
      pix_in_cnt   <= '0;
      pix_out_cnt  <= '0;
      overflow     <= 1'b0;
    end else begin
      if (cap_r) begin
        r_reg <= in_data;
      end
      if (cap_g) begin
        g_reg <= in_data;
      end
      if (cap_b) begin
        b_reg <= in_data;
      end

      // The next R byte can land at the same edge the luma is registered.
      // That is safe because luma reads r_reg before that edge updates it.
      pix_ready    <= cap_b;
      compute_busy <= pix_ready;
      if (pix_ready) begin
        gray_reg <= luma(r_reg, g_reg, b_reg);
      end

      if (compute_busy) begin
        pix_in_cnt <= (pix_in_cnt == LAST_PIX) ? '0 : pix_in_cnt + 1'b1;
      end
      if (pop) begin
        pix_out_cnt <= (pix_out_cnt == LAST_PIX) ? '0 : pix_out_cnt + 1'b1;
      end

      // A pixel with no free slot is lost; the flag stays set until reset or clear.
      if (compute_busy && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------
  gray_out_fifo #(
    .WIDTH (8),
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (compute_busy),
    .push_data (gray_reg),
    .pop       (pop),
    .head      (out_data),
    .not_empty (out_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------
  // Pause and frame completion
  // ---------------------------------------------------------------
  // Pause depends only on registered state. The pixel in gray_reg already
  // has a reserved slot. The source may send one more byte after pause
  // rises, and a pixel needs three bytes, so at most one more pixel can
  // complete and it fits in the last slot.
  logic [CNT_W:0] occupancy;
  assign occupancy  = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(compute_busy);
  assign pause      = (occupancy >= PAUSE_TH);

  assign frame_done = pop && !clear && (pix_out_cnt == LAST_PIX);

endmodule

// File: tb/tb_rgb_grayscaler.sv
module tb_rgb_grayscaler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       pause;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_done;
  logic       overflow;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] got_q[$];
  int         fd_cnt = 0;
  int         fd_at = -1;

  // Frame of four pixels: (255,0,0) (0,0,0) (255,255,255) (0,255,0)
  logic [7:0] frame_bytes [12] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                                   8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0};
  logic [7:0] frame_gray  [4]  = '{8'd77, 8'd0, 8'd255, 8'd149};

  // Six pixels used for the pause test
  logic [7:0] pause_bytes [18] = '{8'd100, 8'd150, 8'd200, 8'd255, 8'd0, 8'd0,
                                   8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255,
                                   8'd0, 8'd255, 8'd0, 8'd10, 8'd20, 8'd30};
  logic [7:0] pause_gray  [6]  = '{8'd141, 8'd77, 8'd0, 8'd255, 8'd149, 8'd18};

  rgb_grayscaler #(.N(2), .M(2), .OUT_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .pause      (pause),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record what the next edge will pop, then apply the inputs and advance one edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (frame_done) begin
      fd_cnt++;
      fd_at = got_q.size();
    end
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic clear_block();
    clear    = 1'b1;
    in_valid = 1'b0;
    tick();
    clear  = 1'b0;
    got_q.delete();
    fd_cnt = 0;
    fd_at  = -1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, pause, frame_done, overflow} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_flags: got v/p/fd/ov=%b want 0000", {out_valid, pause, frame_done, overflow});
    end
    nvec++;
    if (out_data !== 8'd0) begin
      nerr++;
      $display("FAIL reset_data: got %0d want 0", out_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd100;
    tick();
    in_data = 8'd150;
    tick();
    in_data = 8'd200;
    tick();                       // edge t: B accepted
    in_valid = 1'b0;
    in_data  = 8'h5a;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lat_t0_valid: got %b want 0", out_valid);
    end
    tick();                       // t+1
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lat_t1_valid: got %b want 0", out_valid);
    end
    tick();                       // t+2
    nvec++;
    if (out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL lat_t2_valid: got %b want 1", out_valid);
    end
    nvec++;
    if (out_data !== 8'd141) begin
      nerr++;
      $display("FAIL lat_data: got %0d want 141", out_data);
    end
    tick();                       // t+3: popped
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lat_t3_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_block();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b1, frame_bytes[i]);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'hA5);
    nvec++;
    if (got_q.size() !== 4) begin
      nerr++;
      $display("FAIL b2b_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        nvec++;
        if (got_q[i] !== frame_gray[i]) begin
          nerr++;
          $display("FAIL b2b_pix%0d: got %0d want %0d", i, got_q[i], frame_gray[i]);
        end
      end
    end
    nvec++;
    if (fd_cnt !== 1 || fd_at !== 4) begin
      nerr++;
      $display("FAIL b2b_frame_done: got pulses=%0d at pop %0d want 1 at pop 4", fd_cnt, fd_at);
    end
  endtask

  task automatic test_pause();
    int  bi = 0;
    int  edge_n = 0;
    int  first_pause = -1;
    int  pause_drop_bad = 0;
    logic p_old = 1'b0;
    logic p_new = 1'b0;
    logic v;
    clear_block();
    out_ready = 1'b0;
    // The source reacts to pause one cycle late, so one byte slips through after it rises.
    for (int k = 0; k < 25; k++) begin
      v = (bi < 18) && !p_old;
      cycle(v, v ? pause_bytes[bi] : 8'h3c);
      if (v) bi++;
      edge_n++;
      p_old = p_new;
      p_new = pause;
      if (pause && first_pause < 0) first_pause = edge_n;
      if (first_pause >= 0 && !pause) pause_drop_bad++;
    end
    nvec++;
    if (first_pause !== 10) begin
      nerr++;
      $display("FAIL pause_rise_edge: got %0d want 10", first_pause);
    end
    nvec++;
    if (bi !== 11) begin
      nerr++;
      $display("FAIL pause_bytes_taken: got %0d want 11", bi);
    end
    nvec++;
    if (pause_drop_bad !== 0) begin
      nerr++;
      $display("FAIL pause_held: got %0d low cycles want 0", pause_drop_bad);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 150 && !(bi == 18 && got_q.size() == 6); k++) begin
      v = (bi < 18) && !p_old;
      cycle(v, v ? pause_bytes[bi] : 8'h3c);
      if (v) bi++;
      p_old = p_new;
      p_new = pause;
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00);
    nvec++;
    if (got_q.size() !== 6) begin
      nerr++;
      $display("FAIL pause_drain_count: got %0d want 6", got_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        nvec++;
        if (got_q[i] !== pause_gray[i]) begin
          nerr++;
          $display("FAIL pause_pix%0d: got %0d want %0d", i, got_q[i], pause_gray[i]);
        end
      end
    end
    nvec++;
    if (pause !== 1'b0 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL pause_end_state: got pause=%b ovf=%b want 0 0", pause, overflow);
    end
    nvec++;
    if (fd_cnt !== 1 || fd_at !== 4) begin
      nerr++;
      $display("FAIL pause_frame_done: got pulses=%0d at pop %0d want 1 at pop 4", fd_cnt, fd_at);
    end
  endtask

  task automatic test_clear();
    clear_block();
    out_ready = 1'b1;
    cycle(1'b1, 8'd50);
    cycle(1'b1, 8'd60);
    clear = 1'b1;
    cycle(1'b1, 8'd99);
    clear = 1'b0;
    cycle(1'b1, 8'd10);
    cycle(1'b1, 8'd20);
    cycle(1'b1, 8'd30);
    for (int k = 0; k < 6; k++) cycle(1'b0, 8'hff);
    nvec++;
    if (got_q.size() !== 1) begin
      nerr++;
      $display("FAIL clear_count: got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      nvec++;
      if (got_q[0] !== 8'd18) begin
        nerr++;
        $display("FAIL clear_pix: got %0d want 18", got_q[0]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_block();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1'b1, frame_bytes[i]);
    cycle(1'b1, 8'd100);
    cycle(1'b1, 8'd150);
    cycle(1'b1, 8'd200);          // edge 15: fifth pixel complete
    nvec++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_before: got %b want 0", overflow);
    end
    cycle(1'b0, 8'h00);           // edge 16
    nvec++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_edge16: got %b want 0", overflow);
    end
    cycle(1'b0, 8'h00);           // edge 17: fifth pixel dropped
    nvec++;
    if (overflow !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle(1'b0, 8'h00);
    nvec++;
    if (got_q.size() !== 4) begin
      nerr++;
      $display("FAIL ovf_drain_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        nvec++;
        if (got_q[i] !== frame_gray[i]) begin
          nerr++;
          $display("FAIL ovf_pix%0d: got %0d want %0d", i, got_q[i], frame_gray[i]);
        end
      end
    end
    nvec++;
    if (overflow !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    clear_block();
    nvec++;
    if (overflow !== 1'b0) begin
      nerr++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_async_reset();
    clear_block();
    out_ready = 1'b0;
    cycle(1'b1, 8'd10);
    cycle(1'b1, 8'd20);
    cycle(1'b1, 8'd30);
    cycle(1'b1, 8'd255);
    cycle(1'b1, 8'd0);
    cycle(1'b1, 8'd0);
    cycle(1'b1, 8'd1);            // R of an unfinished pixel
    cycle(1'b0, 8'h00);           // second pixel pushed at this edge
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 8'd18) begin
      nerr++;
      $display("FAIL arst_pre: got v=%b d=%0d want v=1 d=18", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, pause, frame_done, overflow} !== 4'b0000 || out_data !== 8'd0) begin
      nerr++;
      $display("FAIL arst_outputs: got v/p/fd/ov=%b d=%0d want 0000 d=0",
               {out_valid, pause, frame_done, overflow}, out_data);
    end
    tick();
    rst_n = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    cycle(1'b1, 8'd0);
    cycle(1'b1, 8'd255);
    cycle(1'b1, 8'd0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 8'h00);
    nvec++;
    if (got_q.size() !== 1) begin
      nerr++;
      $display("FAIL arst_count: got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      nvec++;
      if (got_q[0] !== 8'd149) begin
        nerr++;
        $display("FAIL arst_pix: got %0d want 149", got_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_pause();
    test_clear();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
